// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, synchronises and debounces the
//   column returns, and reports one {row_index, col_index} pair per accepted keypress.
//   The pair feeds the calculator key decoder directly as a 0..15 code.
//
// Build option:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-pulses key_valid after REPEAT_DELAY
//                         clocks and then every REPEAT_PERIOD clocks. When undefined,
//                         exactly one key_valid is produced per press.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   col_in     in   [3:0] raw column lines, active-low, asynchronous to clk
//   row_drive  out  [3:0] active-low one-hot row strobe
//   row_index  out  [3:0] accepted key row (0..3, upper bits always 0)
//   col_index  out  [1:0] accepted key column (0..3)
//   key_valid  out  one-clock pulse when row_index/col_index hold a new key (or a repeat)
//   key_held   out  high while the accepted key remains pressed
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 4,
  parameter int unsigned DEBOUNCE_CNT  = 16,
  parameter int unsigned REPEAT_DELAY  = 4096,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] row_index,
  output logic [1:0] col_index,
  output logic       key_valid,
  output logic       key_held
);

  // Counter width covers the largest parameter so every counter shares one size.
  localparam int unsigned MaxSd  = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int unsigned MaxRp  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned MaxAll = (MaxSd > MaxRp) ? MaxSd : MaxRp;
  localparam int unsigned CntW   = $clog2(MaxAll) + 1;

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] StScan     = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHold     = 2'd2;
  localparam logic [1:0] StRelease  = 2'd3;

  // Two-flop synchroniser on the raw column lines
  logic [3:0] col_meta_q;
  logic [3:0] col_s_q;

  logic [1:0]      state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      cand_row_q, cand_row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [3:0]      row_index_q, row_index_d;
  logic [1:0]      col_index_q, col_index_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  logic            hit;
  logic [1:0]      hit_col;
  logic            cand_high;
  logic [CntW-1:0] cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CntW-1:0] RepDelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RepPeriodLast = CntW'(REPEAT_PERIOD - 1);

  logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;  // set once the first repeat has fired
  logic            rep_fire;
  logic [CntW-1:0] rep_inc;

  assign rep_fire = rep_first_q ? (rep_cnt_q == RepPeriodLast) : (rep_cnt_q == RepDelayLast);
  assign rep_inc  = (rep_cnt_q == {CntW{1'b1}}) ? rep_cnt_q : rep_cnt_q + CntW'(1);
`endif

  always_comb begin
    hit_col = 2'd0;
    // Walk downward so the lowest low column is the one left standing.
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) begin
        hit_col = 2'(i);
      end
    end
  end

  assign hit       = ~&col_s_q;
  assign cand_high = col_s_q[cand_col_q];
  // Saturating increment: counters never wrap back to zero.
  assign cnt_inc   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    row_index_d = row_index_q;
    col_index_d = col_index_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat timing only survives while sitting in HOLD.
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
`endif

    unique case (state_q)
      StScan: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (hit) begin
            cand_row_d = row_q;
            cand_col_d = hit_col;
            state_d    = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StDebounce: begin
        // Row stays frozen on the candidate; any bounce abandons it and moves on.
        if (cand_high) begin
          state_d = StScan;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          row_index_d = {2'b00, cand_row_q};
          col_index_d = cand_col_q;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = StHold;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StHold: begin
        // Only the accepted column matters; other keys are ignored until release.
        if (cand_high) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else begin
          rep_first_d = rep_first_q;
          if (rep_fire) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
`endif
      end

      StRelease: begin
        if (!cand_high) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          key_held_d = 1'b0;
          state_d    = StScan;
          row_d      = 2'd0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d    = StScan;
        row_d      = 2'd0;
        cnt_d      = '0;
        key_held_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'b1111;
      col_s_q     <= 4'b1111;
      state_q     <= StScan;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      row_index_q <= 4'd0;
      col_index_q <= 2'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_meta_q  <= col_in;
      col_s_q     <= col_meta_q;
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      row_index_q <= row_index_d;
      col_index_q <= col_index_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  assign row_drive = ~(4'b0001 << row_q);
  assign row_index = row_index_q;
  assign col_index = col_index_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_in from a pressed-key map,
// a scoreboard queue holds the expected key codes and a monitor pops them on key_valid.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic [3:0] row_index;
  logic [1:0] col_index;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;  // keys[r*4+c] = key at row r, column c pressed

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [5:0] exp_q[$];
  int         pulse_times[$];
  logic       held_prev = 1'b0;
  logic [5:0] last_code = '0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_CNT  (8),
    .REPEAT_DELAY  (64),
    .REPEAT_PERIOD (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_drive (row_drive),
    .row_index (row_index),
    .col_index (col_index),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pressed key shorts its column low while its row is strobed.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_drive[r]) col_in[c] = 1'b0;
      end
    end
  end

  // Scoreboard monitor: a pulse with key_held already high is a repeat of the last key.
  always @(negedge clk) begin
    if (rst) begin
      held_prev <= 1'b0;
    end else begin
      if (key_valid) begin
        pulse_times.push_back(cyc);
        vectors++;
        if (held_prev) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if ({row_index, col_index} !== last_code) begin
            miscompares++;
            $display("FAIL repeat_code: got %h want %h", {row_index, col_index}, last_code);
          end
`else
          miscompares++;
          $display("FAIL extra_pulse: got key_valid while held, code %h want none",
                   {row_index, col_index});
`endif
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_key: got code %h want no key_valid", {row_index, col_index});
        end else begin
          last_code = exp_q.pop_front();
          if ({row_index, col_index} !== last_code) begin
            miscompares++;
            $display("FAIL key_code: got %h want %h", {row_index, col_index}, last_code);
          end
        end
      end
      held_prev <= key_held;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulses(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      #1;
      if (pulse_times.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (!key_held) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    vectors += 5;
    if (row_drive !== 4'b1110) begin
      miscompares++; $display("FAIL rst_row_drive: got %b want 1110", row_drive);
    end
    if (row_index !== 4'd0) begin
      miscompares++; $display("FAIL rst_row_index: got %0d want 0", row_index);
    end
    if (col_index !== 2'd0) begin
      miscompares++; $display("FAIL rst_col_index: got %0d want 0", col_index);
    end
    if (key_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_key_valid: got %b want 0", key_valid);
    end
    if (key_held !== 1'b0) begin
      miscompares++; $display("FAIL rst_key_held: got %b want 0", key_held);
    end
    rst = 1'b0;
    tick(3);
    vectors++;
    if (row_drive !== 4'b1110) begin
      miscompares++; $display("FAIL scan_dwell: got %b want 1110", row_drive);
    end
    tick(1);
    vectors++;
    if (row_drive !== 4'b1101) begin
      miscompares++; $display("FAIL scan_step: got %b want 1101", row_drive);
    end
  endtask

  task automatic test_clean_press;
    int n0;
    bit ok;
    n0 = pulse_times.size();
    exp_q.push_back({4'd2, 2'd3});
    keys[2*4+3] = 1'b1;
    wait_pulses(n0 + 1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL press_detect: got no key_valid want one within 100 clk");
    end
    tick(200);
    vectors += 2;
    if (key_held !== 1'b1) begin
      miscompares++; $display("FAIL hold_key_held: got %b want 1", key_held);
    end
    if (row_drive !== 4'b1011) begin
      miscompares++; $display("FAIL hold_row_frozen: got %b want 1011", row_drive);
    end
`ifndef KEYPAD_AUTOREPEAT_EN
    vectors++;
    if (pulse_times.size() !== n0 + 1) begin
      miscompares++;
      $display("FAIL single_pulse: got %0d pulses want 1", pulse_times.size() - n0);
    end
`endif
    keys = '0;
    tick(9);
    vectors++;
    if (key_held !== 1'b1) begin
      miscompares++; $display("FAIL release_early: got key_held %b want 1 at +9", key_held);
    end
    tick(2);
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++; $display("FAIL release_late: got key_held %b want 0 at +11", key_held);
    end
    tick(4);
  endtask

  task automatic test_glitch;
    int n0;
    bit found;
    logic [3:0] prev;
    n0    = pulse_times.size();
    found = 1'b0;
    prev  = row_drive;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_drive == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = row_drive;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL glitch_row0: got no row0 strobe want one within 40 clk");
    end
    keys[0*4+1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) keys = '0;
      if (k == 6) begin
        vectors++;
        if (row_drive !== 4'b1110) begin
          miscompares++; $display("FAIL glitch_debounce_freeze: got %b want 1110", row_drive);
        end
      end
      if (k == 8) begin
        vectors++;
        if (row_drive !== 4'b1101) begin
          miscompares++; $display("FAIL glitch_resume_row1: got %b want 1101", row_drive);
        end
      end
    end
    tick(40);
    vectors++;
    if (pulse_times.size() !== n0) begin
      miscompares++;
      $display("FAIL glitch_no_key: got %0d pulses want 0", pulse_times.size() - n0);
    end
  endtask

  task automatic test_lowest_col;
    int n0;
    bit ok;
    n0 = pulse_times.size();
    exp_q.push_back({4'd1, 2'd1});
    keys[1*4+1] = 1'b1;
    keys[1*4+3] = 1'b1;
    wait_pulses(n0 + 1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL two_col_detect: got no key_valid want one within 100 clk");
    end
    tick(5);
    keys = '0;
    wait_idle(40, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL two_col_release: got key_held 1 want 0 within 40 clk");
    end
    tick(3);
  endtask

  task automatic test_back_to_back;
    int n0;
    bit ok;
    n0 = pulse_times.size();
    exp_q.push_back({4'd3, 2'd0});
    keys[3*4+0] = 1'b1;
    wait_pulses(n0 + 1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL bounce_first: got no key_valid want one within 100 clk");
    end
    tick(20);
    keys[3*4+0] = 1'b0;
    tick(3);
    keys[3*4+0] = 1'b1;
    tick(30);
    vectors += 2;
    if (pulse_times.size() !== n0 + 1) begin
      miscompares++;
      $display("FAIL bounce_no_repulse: got %0d pulses want 1", pulse_times.size() - n0);
    end
    if (key_held !== 1'b1) begin
      miscompares++; $display("FAIL bounce_still_held: got %b want 1", key_held);
    end
    keys = '0;
    wait_idle(40, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL bounce_release: got key_held 1 want 0 within 40 clk");
    end
    tick(3);
    exp_q.push_back({4'd3, 2'd0});
    keys[3*4+0] = 1'b1;
    wait_pulses(n0 + 2, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL repress: got no second key_valid want one within 100 clk");
    end
    tick(5);
    keys = '0;
    wait_idle(40, ok);
    tick(3);
  endtask

  task automatic test_reset_in_hold;
    int n0;
    bit ok;
    n0 = pulse_times.size();
    exp_q.push_back({4'd2, 2'd0});
    keys[2*4+0] = 1'b1;
    wait_pulses(n0 + 1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL hold_rst_press: got no key_valid want one within 100 clk");
    end
    tick(10);
    rst  = 1'b1;
    keys = '0;
    @(posedge clk);
    #1;
    vectors += 5;
    if (row_drive !== 4'b1110) begin
      miscompares++; $display("FAIL hold_rst_row_drive: got %b want 1110", row_drive);
    end
    if (key_held !== 1'b0) begin
      miscompares++; $display("FAIL hold_rst_key_held: got %b want 0", key_held);
    end
    if (row_index !== 4'd0) begin
      miscompares++; $display("FAIL hold_rst_row_index: got %0d want 0", row_index);
    end
    if (col_index !== 2'd0) begin
      miscompares++; $display("FAIL hold_rst_col_index: got %0d want 0", col_index);
    end
    if (key_valid !== 1'b0) begin
      miscompares++; $display("FAIL hold_rst_key_valid: got %b want 0", key_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(3);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat;
    int n0;
    bit ok;
    int offs[4];
    offs = '{64, 80, 96, 112};
    n0 = pulse_times.size();
    exp_q.push_back({4'd0, 2'd0});
    keys[0] = 1'b1;
    wait_pulses(n0 + 1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL repeat_accept: got no key_valid want one within 100 clk");
    end else begin
      for (int i = 0; i < 200 && (cyc - pulse_times[n0]) < 120; i++) @(negedge clk);
    end
    keys = '0;
    wait_idle(40, ok);
    vectors++;
    if (pulse_times.size() !== n0 + 5) begin
      miscompares++;
      $display("FAIL repeat_count: got %0d pulses want 5", pulse_times.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (pulse_times[n0+1+i] - pulse_times[n0] !== offs[i]) begin
          miscompares++;
          $display("FAIL repeat_offset%0d: got +%0d want +%0d", i,
                   pulse_times[n0+1+i] - pulse_times[n0], offs[i]);
        end
      end
    end
    tick(3);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_lowest_col();
    test_back_to_back();
    test_reset_in_hold();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
